// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter.
// Contents:
//   state_e           one-hot (5-bit) transmitter state encoding
//   CLKS_PER_BIT_DEF  default clocks per serial bit (50 MHz / 115200)
//   even_parity()     even-parity bit of a data byte
package uart_pkg;

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_START  = 5'b00010,
      S_DATA   = 5'b00100,
      S_PARITY = 5'b01000,
      S_STOP   = 5'b10000
   } state_e;

   localparam int unsigned CLKS_PER_BIT_DEF = 434;

   // Even parity: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1
// while enabled and raises tick_o on the last cycle of each bit period.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   en_i    count enable (a frame is on the line)
//   clr_i   synchronous clear (holds the counter at zero while idle)
//   tick_o  bit-boundary strobe, high on the final cycle of a bit
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = en_i & (cnt_q == LAST);

   // Next count: wrap at each bit boundary, hold at zero when cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: 8N1 (or 8N2) frames from a one-byte holding
// register into a shift register, LSB first, idle-high line.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit(s).
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset (aborts any frame)
//   tx_data   byte to send, captured when tx_valid && tx_ready
//   tx_valid  producer has a byte
//   tx_ready  holding register empty (registered)
//   busy      a frame is being sent
//   tx        serial line (registered, idle high)
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx
);

   state_e     state_q;
   state_e     state_d;
   logic [7:0] hold_q;
   logic [7:0] shift_q;
   logic       ready_q;
   logic       tx_q;
   logic [2:0] idx_q;
   logic       stop_q;

   logic       tick_s;
   logic       load_s;
   logic       accept_s;
   logic       active_s;
   logic       stop_last_s;
   logic       tx_s;

   assign accept_s    = tx_valid & ready_q;
   assign active_s    = (state_q != S_IDLE);
   assign stop_last_s = (stop_q == 1'(STOP_BITS - 1));

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i  (clk),
      .rst_i  (rst),
      .en_i   (active_s),
      .clr_i  (~active_s),
      .tick_o (tick_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; load_s moves the held byte into the shifter.
   // A full holding register at the end of the stop bit chains straight
   // into the next start bit with no idle cycle.
   always_comb begin
      state_d = state_q;
      load_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!ready_q) begin
               state_d = S_START;
               load_s  = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (tick_s) begin
               state_d = S_DATA;
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (tick_s && (idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end else begin
               state_d = S_DATA;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (tick_s) begin
               state_d = S_STOP;
            end else begin
               state_d = S_PARITY;
            end
         end
`endif
         S_STOP: begin
            if (tick_s && stop_last_s) begin
               if (!ready_q) begin
                  state_d = S_START;
                  load_s  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Line level for the current state. The shifter rotates rather than
   // shifts, so after eight bits it holds the original byte again and the
   // parity bit can be derived from it directly.
   always_comb begin
      tx_s = 1'b1;
      case (state_q)
         S_IDLE:   tx_s = 1'b1;
         S_START:  tx_s = 1'b0;
         S_DATA:   tx_s = shift_q[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: tx_s = even_parity(shift_q);
`endif
         S_STOP:   tx_s = 1'b1;
         default:  tx_s = 1'b1;
      endcase
   end

   // Holding/shift registers, bit and stop counters, registered line.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q  <= 8'h00;
         shift_q <= 8'h00;
         ready_q <= 1'b1;
         idx_q   <= 3'd0;
         stop_q  <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         tx_q <= tx_s;
         // accept and load never coincide: load needs a full holding register
         if (accept_s) begin
            hold_q  <= tx_data;
            ready_q <= 1'b0;
         end else if (load_s) begin
            ready_q <= 1'b1;
         end else begin
            ready_q <= ready_q;
         end
         if (load_s) begin
            shift_q <= hold_q;
            idx_q   <= 3'd0;
            stop_q  <= 1'b0;
         end else if (tick_s) begin
            case (state_q)
               S_DATA: begin
                  shift_q <= {shift_q[0], shift_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
               end
               S_STOP: begin
                  stop_q <= stop_last_s ? 1'b0 : 1'b1;
               end
               default: begin
                  shift_q <= shift_q;
               end
            endcase
         end else begin
            shift_q <= shift_q;
         end
      end
   end

   assign tx       = tx_q;
   assign tx_ready = ready_q;
   assign busy     = active_s;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed self-checking bench for uart_frame_tx with CLKS_PER_BIT=4,
// STOP_BITS=1. Honours UART_TX_PARITY_EN for the frame length and the
// parity-bit cases.
module tb_uart_frame_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif
   localparam int FRAME = (PAR_EN ? 11 : 10) * CPB;
   localparam int NRAND = 200;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       busy;
   logic       tx;

   int checks   = 0;
   int failures = 0;

   logic cap [0:127];
   logic [7:0] exp_q [$];
   logic [7:0] rx_q  [$];

   // serial decoder state
   logic       dec_act = 1'b0;
   int         dec_cnt = 0;
   logic [7:0] dec_byte = 8'h00;
   int         frm_err = 0;
   int         par_err = 0;

   uart_frame_tx #(
      .CLKS_PER_BIT (CPB),
      .STOP_BITS    (1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .tx       (tx)
   );

   always #5 clk = ~clk;

   // Serial decoder: samples mid-bit on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         dec_act <= 1'b0;
      end else if (!dec_act) begin
         if (tx === 1'b0) begin
            dec_act <= 1'b1;
            dec_cnt <= 1;
         end
      end else begin
         dec_cnt <= dec_cnt + 1;
         for (int k = 0; k < 8; k++) begin
            if (dec_cnt == (1 + k) * CPB + CPB / 2) dec_byte[k] <= tx;
         end
         if (PAR_EN && dec_cnt == 9 * CPB + CPB / 2) begin
            if (tx !== ^dec_byte) par_err <= par_err + 1;
         end
         if (dec_cnt == FRAME - CPB / 2) begin
            dec_act <= 1'b0;
            rx_q.push_back(dec_byte);
            if (tx !== 1'b1) frm_err <= frm_err + 1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level i cycles into a frame carrying d.
   function automatic logic exp_bit(input logic [7:0] d, input int i);
      int b;
      b = i / CPB;
      if (b == 0) return 1'b0;
      else if (b <= 8) return d[b-1];
      else if (PAR_EN && b == 9) return ^d;
      else return 1'b1;
   endfunction

   // Decode a byte from the capture buffer, frame starting at index base.
   function automatic logic [7:0] dec_cap(input int base);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = cap[base + (1 + k) * CPB + CPB / 2];
      return r;
   endfunction

   // One isolated frame: latency, line shape, busy length, decoded byte.
   task automatic send_one(input logic [7:0] d, input string tag);
      int bcnt;
      int errs;
      int first0;
      bcnt = 0;
      errs = 0;
      first0 = -1;
      tx_valid = 1'b1;
      tx_data  = d;
      step();
      tx_valid = 1'b0;
      chk({tag, "_ready_low"}, tx_ready, 1'b0);
      for (int c = 0; c < FRAME + 12; c++) begin
         step();
         cap[c] = tx;
         if (busy) bcnt++;
         if (first0 < 0 && tx === 1'b0) first0 = c;
      end
      chk({tag, "_latency"}, first0 + 1, 2);
      for (int i = 0; i < FRAME; i++) if (cap[1 + i] !== exp_bit(d, i)) errs++;
      for (int i = FRAME + 1; i < FRAME + 12; i++) if (cap[i] !== 1'b1) errs++;
      chk({tag, "_line_errs"}, errs, 0);
      chk({tag, "_busy_cycles"}, bcnt, FRAME);
      chk({tag, "_decoded"}, dec_cap(1), d);
      chk({tag, "_ready_end"}, tx_ready, 1'b1);
   endtask

   int idle_bad;
   int errs2;
   int lows;
   int bz;
   int sent;
   int guard;
   bit have;
   logic [7:0] cur;

   initial begin
      // Reset and idle line
      rst = 1'b1;
      tx_valid = 1'b0;
      step(); step(); step();
      chk("rst_tx", tx, 1'b1);
      chk("rst_ready", tx_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      idle_bad = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         if (tx !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) idle_bad++;
      end
      chk("idle_20", idle_bad, 0);

      // Single 0xFF frame
      send_one(8'hFF, "ff");

      // Back-to-back 0x55 then 0xA5 with tx_valid held high
      tx_valid = 1'b1;
      tx_data  = 8'h55;
      step();
      tx_data  = 8'hA5;
      chk("b2b_ready_low", tx_ready, 1'b0);
      step();
      chk("b2b_ready_free", tx_ready, 1'b1);
      step();
      tx_valid = 1'b0;
      chk("b2b_ready_held", tx_ready, 1'b0);
      for (int c = 0; c < 2 * FRAME + 10; c++) begin
         cap[c] = tx;
         step();
      end
      errs2 = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (cap[i] !== exp_bit(8'h55, i)) errs2++;
         if (cap[FRAME + i] !== exp_bit(8'hA5, i)) errs2++;
      end
      for (int i = 2 * FRAME; i < 2 * FRAME + 10; i++) if (cap[i] !== 1'b1) errs2++;
      chk("b2b_line_errs", errs2, 0);
      chk("b2b_byte0", dec_cap(0), 8'h55);
      chk("b2b_byte1", dec_cap(FRAME), 8'hA5);

      // Reset in the middle of 0x3C with a second byte held
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      step();
      tx_data  = 8'h99;
      step();
      step();
      tx_valid = 1'b0;
      chk("abort_held", tx_ready, 1'b0);
      chk("abort_start", tx, 1'b0);
      repeat (17) step();
      chk("abort_bit3", tx, 1'b1);
      chk("abort_busy", busy, 1'b1);
      rst = 1'b1;
      tx_valid = 1'b1;
      tx_data = 8'h77;
      step();
      chk("abort_tx", tx, 1'b1);
      chk("abort_ready", tx_ready, 1'b1);
      chk("abort_busy0", busy, 1'b0);
      step();
      rst = 1'b0;
      tx_valid = 1'b0;
      lows = 0;
      bz = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (tx !== 1'b1) lows++;
         if (busy !== 1'b0) bz++;
      end
      chk("abort_no_frame", lows, 0);
      chk("abort_no_busy", bz, 0);
      chk("abort_ready_after", tx_ready, 1'b1);

`ifdef UART_TX_PARITY_EN
      // Parity bit values
      send_one(8'h07, "par07");
      chk("par07_bit", cap[1 + 9 * CPB + CPB / 2], 1'b1);
      send_one(8'h03, "par03");
      chk("par03_bit", cap[1 + 9 * CPB + CPB / 2], 1'b0);
`endif

      // Random tx_valid toggling over many bytes
      rx_q.delete();
      exp_q.delete();
      sent = 0;
      guard = 0;
      have = 1'b0;
      cur = 8'h00;
      while (sent < NRAND && guard < NRAND * (FRAME + 10)) begin
         if (!have) begin
            cur  = 8'($urandom_range(0, 255));
            have = 1'b1;
         end
         tx_valid = ($urandom_range(0, 3) != 0);
         tx_data  = cur;
         if (tx_valid && tx_ready) begin
            exp_q.push_back(cur);
            sent++;
            have = 1'b0;
         end
         step();
         guard++;
      end
      tx_valid = 1'b0;
      chk("rand_sent", sent, NRAND);
      guard = 0;
      while (rx_q.size() < exp_q.size() && guard < 4 * FRAME) begin
         step();
         guard++;
      end
      repeat (FRAME) step();
      chk("rand_count", rx_q.size(), exp_q.size());
      errs2 = 0;
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         if (rx_q[i] !== exp_q[i]) errs2++;
      end
      chk("rand_data_errs", errs2, 0);
      chk("rand_framing", frm_err, 0);
      chk("rand_parity", par_err, 0);
      chk("rand_idle_end", busy, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
